// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, datapath widths, the
// divide-by-zero result code and the scheduler FSM state type.
package alu_pkg;

  localparam int OPND_W = 4;
  localparam int RES_W  = 8;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_NAND = 3'd6;
  localparam logic [2:0] OP_NOR  = 3'd7;

  localparam logic [RES_W-1:0] DIV0_RESULT = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or
// above ptr, wrapping from N-1 back to 0.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  always_comb begin
    logic found;
    int   idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found          = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one registered ALU among NUM_REQ requesters: round-robin grant,
// operand issue, latency wait, tagged response; divide-by-zero is trapped locally.
module alu_req_scheduler
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ALU_LAT = 1,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [OPND_W*NUM_REQ-1:0] req_in1,
  input  logic [OPND_W*NUM_REQ-1:0] req_in2,
  input  logic [3*NUM_REQ-1:0]      req_opcode,
  output logic [OPND_W-1:0]         alu_in1,
  output logic [OPND_W-1:0]         alu_in2,
  output logic [2:0]                alu_opcode,
  input  logic [RES_W-1:0]          alu_out,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [RES_W-1:0]          rsp_data,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [1:0]                dbg_state
);

  localparam int CW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

  // Handshake: a request transfers on the edge where req_valid[i] && req_ready[i];
  // a response transfers on the edge where rsp_valid && rsp_ready. Both sides hold
  // valid and payload stable until the transfer.

  sched_state_e      state_q, state_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [ID_W-1:0]   gnt_q, gnt_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [OPND_W-1:0] in1_q, in1_d, in2_q, in2_d;
  logic [2:0]        op_q, op_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [RES_W-1:0]  rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0]    arb_idx;
  logic [OPND_W-1:0]  sel_in1, sel_in2;
  logic [2:0]         sel_op;
  logic               sel_div0;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  assign sel_in1  = req_in1[OPND_W*arb_idx +: OPND_W];
  assign sel_in2  = req_in2[OPND_W*arb_idx +: OPND_W];
  assign sel_op   = req_opcode[3*arb_idx +: 3];
  assign sel_div0 = (sel_op == OP_DIV) && (sel_in2 == '0);

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    in1_d       = in1_q;
    in2_d       = in2_q;
    op_d        = op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    req_ready   = '0;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          req_ready = arb_grant & {NUM_REQ{reset}};
          gnt_d     = arb_idx;
          if (sel_div0) begin
            rsp_id_d    = arb_idx;
            rsp_data_d  = DIV0_RESULT;
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end else begin
            in1_d   = sel_in1;
            in2_d   = sel_in2;
            op_d    = sel_op;
            cnt_d   = CW'(ALU_LAT);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          rsp_data_d  = alu_out;
          rsp_id_d    = gnt_q;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_d        = (gnt_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_q + ID_W'(1);
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      rr_q        <= '0;
      gnt_q       <= '0;
      cnt_q       <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      op_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      op_q        <= op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign alu_in1    = in1_q;
  assign alu_in2    = in2_q;
  assign alu_opcode = op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != ST_IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Bench for alu_req_scheduler: table-driven single operations plus arbitration,
// backpressure, reset-abort and fairness sequences, with a small ALU model.
module tb_alu_req_scheduler;
  import alu_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ALU_LAT = 1;

  logic        clock;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_in1;
  logic [15:0] req_in2;
  logic [11:0] req_opcode;
  logic [3:0]  alu_in1;
  logic [3:0]  alu_in2;
  logic [2:0]  alu_opcode;
  logic [7:0]  alu_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic        busy;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  logic [10:0] exp_q[$];
  logic [1:0]  exp_gnt_q[$];

  alu_req_scheduler #(.NUM_REQ(NUM_REQ), .ALU_LAT(ALU_LAT)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_in1    (req_in1),
    .req_in2    (req_in2),
    .req_opcode (req_opcode),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / ALU model ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
    case (op)
      OP_ADD:  alu_ref = {4'h0, a} + {4'h0, b};
      OP_SUB:  alu_ref = {4'h0, a} - {4'h0, b};
      OP_MUL:  alu_ref = {4'h0, a} * {4'h0, b};
      OP_DIV:  alu_ref = (b == 4'h0) ? 8'hFF : {4'h0, a / b};
      OP_OR:   alu_ref = {4'h0, a | b};
      OP_AND:  alu_ref = {4'h0, a & b};
      OP_NAND: alu_ref = {4'h0, ~(a & b)};
      default: alu_ref = {4'h0, ~(a | b)};
    endcase
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) alu_out <= 8'h00;
    else        alu_out <= alu_ref(alu_in1, alu_in2, alu_opcode);
  end

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic note_timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out", name);
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clock) begin
    if (reset && req_ready != 4'h0) begin
      if (exp_gnt_q.size() == 0) begin
        check("unexpected_grant", {28'h0, req_ready}, 32'h0);
      end else begin
        logic [1:0] g;
        g = exp_gnt_q.pop_front();
        check("grant", {28'h0, req_ready}, 32'h1 << g);
      end
    end
    if (reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", {21'h0, rsp_id, rsp_err, rsp_data}, 32'h0);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        check("rsp_id_err_data", {21'h0, rsp_id, rsp_err, rsp_data}, {21'h0, e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_payload(input int id, input logic [3:0] a, input logic [3:0] b,
                             input logic [2:0] op);
    req_in1[4*id +: 4]    = a;
    req_in2[4*id +: 4]    = b;
    req_opcode[3*id +: 3] = op;
  endtask

  task automatic expect_op(input logic [1:0] id, input logic err, input logic [7:0] data);
    exp_gnt_q.push_back(id);
    exp_q.push_back({id, err, data});
  endtask

  task automatic wait_grant(input int id, output logic ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (n < 40 && !ok) begin
      @(negedge clock);
      if (req_ready[id]) ok = 1'b1;
      n++;
    end
    if (!ok) note_timeout("wait_grant");
  endtask

  // Drops each requester's valid after its grant; returns once all are served.
  task automatic service(input int max_cyc);
    int n;
    logic [3:0] rdy;
    logic done;
    n    = 0;
    done = 1'b0;
    while (!done && n < max_cyc) begin
      @(negedge clock);
      if (req_valid == 4'h0 && !busy) begin
        done = 1'b1;
      end else begin
        rdy = req_ready;
        @(posedge clock);
        #1 req_valid = req_valid & ~rdy;
        n++;
      end
    end
    if (!done) note_timeout("service");
  endtask

  task automatic reset_pulse();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  typedef struct {
    logic [1:0] id;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [7:0] data;
    logic       err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic ok;
    int   lat;
    logic [3:0] s_in1, s_in2;
    logic [2:0] s_op;
    logic [1:0] s_id;
    logic [7:0] s_data;
    logic       s_err;
    int   ngr;
    int   lim;

    vecs[0] = '{2'd0, 4'd3,  4'd4,  OP_ADD,  8'h07, 1'b0};
    vecs[1] = '{2'd1, 4'd9,  4'd7,  OP_MUL,  8'h3F, 1'b0};
    vecs[2] = '{2'd2, 4'd12, 4'd5,  OP_DIV,  8'h02, 1'b0};
    vecs[3] = '{2'd3, 4'd5,  4'd0,  OP_DIV,  8'hFF, 1'b1};
    vecs[4] = '{2'd0, 4'd3,  4'd5,  OP_SUB,  8'hFE, 1'b0};
    vecs[5] = '{2'd1, 4'd12, 4'd10, OP_AND,  8'h08, 1'b0};
    vecs[6] = '{2'd2, 4'd12, 4'd10, OP_NAND, 8'h07, 1'b0};
    vecs[7] = '{2'd3, 4'd12, 4'd10, OP_NOR,  8'h01, 1'b0};
    vecs[8] = '{2'd0, 4'd5,  4'd10, OP_OR,   8'h0F, 1'b0};
    vecs[9] = '{2'd1, 4'd15, 4'd15, OP_MUL,  8'hE1, 1'b0};

    // ---------------- reset state ----------------
    reset      = 1'b0;
    req_valid  = 4'hF;
    req_in1    = 16'h1234;
    req_in2    = 16'h5678;
    req_opcode = 12'h0;
    rsp_ready  = 1'b1;
    #12;
    check("rst_req_ready", {28'h0, req_ready}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    check("rst_rsp_id_data", {22'h0, rsp_id, rsp_data}, 32'h0);
    check("rst_alu_regs", {21'h0, alu_in1, alu_in2, alu_opcode}, 32'h0);
    check("rst_state", {30'h0, dbg_state}, 32'h0);
    req_valid = 4'h0;
    @(negedge clock);
    reset = 1'b1;

    // ---------------- table-driven single operations ----------------
    for (int i = 0; i < 10; i++) begin
      set_payload(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op);
      expect_op(vecs[i].id, vecs[i].err, vecs[i].data);
      @(posedge clock);
      #1 req_valid[vecs[i].id] = 1'b1;
      wait_grant(vecs[i].id, ok);
      s_in1 = alu_in1;
      s_in2 = alu_in2;
      s_op  = alu_opcode;
      @(posedge clock);
      #1 req_valid = 4'h0;
      lat = 1;
      @(negedge clock);
      while (!rsp_valid && lat < 20) begin
        @(negedge clock);
        lat++;
      end
      check("rsp_latency", lat, vecs[i].err ? 1 : ALU_LAT + 2);
      check("busy_in_resp", {31'h0, busy}, 32'h1);
      if (vecs[i].err)
        check("div0_alu_untouched", {21'h0, alu_in1, alu_in2, alu_opcode},
              {21'h0, s_in1, s_in2, s_op});
      service(20);
    end

    // ---------------- simultaneous requests, pointer from 0 ----------------
    reset_pulse();
    set_payload(1, 4'd9, 4'd7, OP_MUL);
    set_payload(2, 4'd12, 4'd5, OP_DIV);
    expect_op(2'd1, 1'b0, 8'h3F);
    expect_op(2'd2, 1'b0, 8'h02);
    @(posedge clock);
    #1 req_valid = 4'b0110;
    service(40);

    // pointer is now 3: requester 3 wins over requester 0
    set_payload(3, 4'd5, 4'd0, OP_DIV);
    set_payload(0, 4'd3, 4'd4, OP_ADD);
    expect_op(2'd3, 1'b1, 8'hFF);
    expect_op(2'd0, 1'b0, 8'h07);
    @(posedge clock);
    #1 req_valid = 4'b1001;
    service(40);

    // ---------------- response backpressure ----------------
    rsp_ready = 1'b0;
    set_payload(1, 4'd2, 4'd2, OP_ADD);
    set_payload(2, 4'd6, 4'd9, OP_OR);
    expect_op(2'd1, 1'b0, 8'h04);
    expect_op(2'd2, 1'b0, 8'h0F);
    @(posedge clock);
    #1 req_valid[1] = 1'b1;
    wait_grant(1, ok);
    @(posedge clock);
    #1 req_valid = 4'b0100;
    lim = 0;
    @(negedge clock);
    while (!rsp_valid && lim < 20) begin
      @(negedge clock);
      lim++;
    end
    s_id   = rsp_id;
    s_data = rsp_data;
    s_err  = rsp_err;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("bp_hold", {19'h0, rsp_valid, busy, req_ready, rsp_id, rsp_err, rsp_data},
            {19'h0, 1'b1, 1'b1, 4'h0, s_id, s_err, s_data});
    end
    @(posedge clock);
    #1 rsp_ready = 1'b1;
    @(posedge clock);
    #1 check("bp_released", {31'h0, rsp_valid}, 32'h0);
    service(40);

    // ---------------- reset during WAIT ----------------
    set_payload(0, 4'd7, 4'd8, OP_ADD);
    exp_gnt_q.push_back(2'd0);
    @(posedge clock);
    #1 req_valid[0] = 1'b1;
    wait_grant(0, ok);
    @(posedge clock);
    #1 req_valid = 4'h0;
    check("wait_entered", {30'h0, dbg_state}, {30'h0, ST_WAIT});
    #2 reset = 1'b0;
    #1;
    check("abort_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("abort_alu_regs", {21'h0, alu_in1, alu_in2, alu_opcode}, 32'h0);
    check("abort_busy_state", {29'h0, busy, dbg_state}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) @(negedge clock);
    check("abort_no_rsp", {31'h0, rsp_valid}, 32'h0);

    // ---------------- fairness: all four continuously valid ----------------
    for (int k = 0; k < 4; k++) set_payload(k, 4'(k + 1), 4'h8, OP_OR);
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 4; k++)
        expect_op(2'(k), 1'b0, alu_ref(4'(k + 1), 4'h8, OP_OR));
    @(posedge clock);
    #1 req_valid = 4'hF;
    ngr = 0;
    lim = 0;
    while (ngr < 12 && lim < 200) begin
      @(negedge clock);
      if (req_ready != 4'h0) ngr++;
      lim++;
    end
    if (ngr < 12) note_timeout("fairness_grants");
    @(posedge clock);
    #1 req_valid = 4'h0;
    service(40);

    // ---------------- final report ----------------
    repeat (3) @(negedge clock);
    check("rsp_queue_drained", exp_q.size(), 0);
    check("grant_queue_drained", exp_gnt_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
